// File: rtl/fir_circmem_mc_if.sv
// Bus bundle for fir_circmem_mc: frame input side and history-stream output side.
// Parameters must match those of the fir_circmem_mc instance it is bound to.
interface fir_circmem_mc_if #(
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned AWIDTH = 6,
   parameter int unsigned NCH    = 2
);
   localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic                    clr;
   logic                    din_vld;
   logic [NCH*DWIDTH-1:0]   din;
   logic [AWIDTH-1:0]       taps_m1;
   logic [DWIDTH-1:0]       dout;
   logic [CHW-1:0]          dout_ch;
   logic [AWIDTH-1:0]       dout_tap;
   logic                    drdy;
   logic                    dfirst;
   logic                    dlast;
   logic                    busy;
   logic                    ovf;

   modport master (
      output clr, din_vld, din, taps_m1,
      input  dout, dout_ch, dout_tap, drdy, dfirst, dlast, busy, ovf
   );

   modport slave (
      input  clr, din_vld, din, taps_m1,
      output dout, dout_ch, dout_tap, drdy, dfirst, dlast, busy, ovf
   );
endinterface

// File: rtl/fir_circmem_mc.sv
// Multi-channel circular sample history: one frame write, then streams the newest
// taps_m1+1 samples of every channel, newest first, one word per clock.
module fir_circmem_mc #(
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned AWIDTH = 6,
   parameter int unsigned NCH    = 2
) (
   input logic             clk,
   input logic             rst_n,
   fir_circmem_mc_if.slave bus
);
   localparam int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned DEPTH = 2 ** AWIDTH;

   typedef enum logic [0:0] {StIdle, StRun} state_t;

   logic [DWIDTH-1:0] mem [NCH][DEPTH];

   state_t            state_q;
   logic [AWIDTH-1:0] wp_q, base_q, ntap_q, k_q;
   logic [CHW-1:0]    ch_q;
   logic [AWIDTH:0]   fill_q;
   logic [DWIDTH-1:0] dout_q;
   logic [CHW-1:0]    dout_ch_q;
   logic [AWIDTH-1:0] dout_tap_q;
   logic              drdy_q, dfirst_q, dlast_q, ovf_q;

   logic [AWIDTH-1:0] rd_addr;
   logic              last_tap, last_beat, accept;

   // Ring walks backwards from the newest sample; full-depth runs end at base+1.
   assign rd_addr   = base_q - k_q;
   assign last_tap  = (k_q == ntap_q);
   assign last_beat = last_tap && (ch_q == CHW'(NCH - 1));
   assign accept    = (state_q == StIdle) && bus.din_vld && !bus.clr;

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            mem[c][wp_q] <= bus.din[c*DWIDTH +: DWIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wp_q       <= '0;
         base_q     <= '0;
         ntap_q     <= '0;
         k_q        <= '0;
         ch_q       <= '0;
         fill_q     <= '0;
         dout_q     <= '0;
         dout_ch_q  <= '0;
         dout_tap_q <= '0;
         drdy_q     <= 1'b0;
         dfirst_q   <= 1'b0;
         dlast_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else if (bus.clr) begin
         // Memory is left alone; fill=0 masks whatever it still holds.
         state_q  <= StIdle;
         wp_q     <= '0;
         fill_q   <= '0;
         ovf_q    <= 1'b0;
         drdy_q   <= 1'b0;
         dfirst_q <= 1'b0;
         dlast_q  <= 1'b0;
      end else if (state_q == StIdle) begin
         drdy_q   <= 1'b0;
         dfirst_q <= 1'b0;
         dlast_q  <= 1'b0;
         if (bus.din_vld) begin
            base_q <= wp_q;
            wp_q   <= wp_q + 1'b1;
            if (fill_q != (AWIDTH + 1)'(DEPTH)) fill_q <= fill_q + 1'b1;
            ntap_q  <= bus.taps_m1;
            k_q     <= '0;
            ch_q    <= '0;
            state_q <= StRun;
         end
      end else begin
         if (bus.din_vld) ovf_q <= 1'b1;
         dout_q     <= ({1'b0, k_q} >= fill_q) ? '0 : mem[ch_q][rd_addr];
         dout_ch_q  <= ch_q;
         dout_tap_q <= k_q;
         drdy_q     <= 1'b1;
         dfirst_q   <= (ch_q == '0) && (k_q == '0);
         dlast_q    <= last_beat;
         if (last_tap) begin
            k_q  <= '0;
            ch_q <= ch_q + 1'b1;
         end else begin
            k_q <= k_q + 1'b1;
         end
         if (last_beat) state_q <= StIdle;
      end
   end

   assign bus.dout     = dout_q;
   assign bus.dout_ch  = dout_ch_q;
   assign bus.dout_tap = dout_tap_q;
   assign bus.drdy     = drdy_q;
   assign bus.dfirst   = dfirst_q;
   assign bus.dlast    = dlast_q;
   assign bus.ovf      = ovf_q;
   assign bus.busy     = (state_q == StRun);
endmodule

// File: tb/tb_fir_circmem_mc.sv
// Bench for fir_circmem_mc: directed steps with random data, checked against a
// frame-history queue model (newest frame at the back).
module tb_fir_circmem_mc;
   localparam int unsigned DWIDTH = 16;
   localparam int unsigned AWIDTH = 6;
   localparam int unsigned NCH    = 2;

   logic tb_clk_64 = 1'b0;
   logic tb_rstn   = 1'b0;

   fir_circmem_mc_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .NCH(NCH)) bus ();

   fir_circmem_mc #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .NCH(NCH)) dut (
      .clk   (tb_clk_64),
      .rst_n (tb_rstn),
      .bus   (bus)
   );

   always #5 tb_clk_64 = ~tb_clk_64;

   int unsigned tests = 0;
   int unsigned fails = 0;
   logic [31:0] hist [$];
   bit          ovf_exp = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_word(input int c, input int k);
      logic [31:0] f;
      if (k >= hist.size()) return 16'h0;
      f = hist[hist.size() - 1 - k];
      return f[c*16 +: 16];
   endfunction

   task automatic tick();
      @(posedge tb_clk_64);
      #1;
   endtask

   task automatic start_frame(input logic [31:0] d, input int taps);
      bus.din     = d;
      bus.taps_m1 = AWIDTH'(taps);
      bus.din_vld = 1'b1;
      tick();
      bus.din_vld = 1'b0;
      hist.push_back(d);
      if (hist.size() > 64) void'(hist.pop_front());
      check("busy_after_accept", 32'(bus.busy), 32'd1);
      check("drdy_at_accept", 32'(bus.drdy), 32'd0);
   endtask

   // Checks `cnt` beats of a run with `taps` taps/channel; optionally pokes frames
   // (which must be dropped) and scrambles taps_m1 (which must be ignored).
   task automatic check_beats(input int taps, input int cnt, input bit poke_en);
      int n;
      bit poke;
      n = NCH * (taps + 1);
      for (int b = 0; b < cnt; b++) begin
         poke        = poke_en && ($urandom_range(0, 3) == 0);
         bus.din_vld = poke;
         bus.din     = $urandom;
         if (poke_en) bus.taps_m1 = AWIDTH'($urandom);
         tick();
         if (poke) ovf_exp = 1'b1;
         check("drdy", 32'(bus.drdy), 32'd1);
         check("dout", 32'(bus.dout), 32'(exp_word(b / (taps + 1), b % (taps + 1))));
         check("dout_ch", 32'(bus.dout_ch), 32'(b / (taps + 1)));
         check("dout_tap", 32'(bus.dout_tap), 32'(b % (taps + 1)));
         check("dfirst", 32'(bus.dfirst), 32'(b == 0));
         check("dlast", 32'(bus.dlast), 32'(b == n - 1));
         check("busy", 32'(bus.busy), 32'(b != n - 1));
         check("ovf", 32'(bus.ovf), 32'(ovf_exp));
      end
      bus.din_vld = 1'b0;
   endtask

   task automatic run_frame(input logic [31:0] d, input int taps, input bit poke_en);
      start_frame(d, taps);
      check_beats(taps, NCH * (taps + 1), poke_en);
      tick();
      check("drdy_idle", 32'(bus.drdy), 32'd0);
      check("busy_idle", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      bus.clr     = 1'b0;
      bus.din_vld = 1'b0;
      bus.din     = '0;
      bus.taps_m1 = '0;
      #1;
      check("rst_drdy", 32'(bus.drdy), 32'd0);
      check("rst_dout", 32'(bus.dout), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      tick();
      tb_rstn = 1'b1;
      tick();

      // First frame after reset: only tap 0 holds data.
      run_frame(32'h0B00_0A00, 3, 1'b0);
      check("first_run_ch0_tap0", 32'(exp_word(0, 0)), 32'h0A00);

      // 70 frames through a 64-deep ring at the maximum rate.
      for (int n = 1; n <= 70; n++) run_frame({16'(n + 'h100), 16'(n)}, 63, 1'b0);
      check("ovf_after_70", 32'(bus.ovf), 32'd0);

      // Strobe held high with single-tap runs: accept every 3rd edge.
      bus.taps_m1 = '0;
      for (int j = 0; j < 12; j++) begin
         d           = $urandom;
         bus.din     = d;
         bus.din_vld = 1'b1;
         tick();
         if (j % 3 == 0) begin
            hist.push_back(d);
            if (hist.size() > 64) void'(hist.pop_front());
            check("hold_drdy_accept", 32'(bus.drdy), 32'd0);
            check("hold_busy_accept", 32'(bus.busy), 32'd1);
         end else begin
            ovf_exp = 1'b1;
            check("hold_drdy", 32'(bus.drdy), 32'd1);
            check("hold_dout", 32'(bus.dout), 32'(exp_word(j % 3 - 1, 0)));
            check("hold_ch", 32'(bus.dout_ch), 32'(j % 3 - 1));
         end
         check("hold_ovf", 32'(bus.ovf), 32'(ovf_exp));
      end
      bus.din_vld = 1'b0;
      tick();

      // clr at beat 3 aborts the run, clears ovf and history; strobe on clr is lost.
      start_frame($urandom, 3);
      check_beats(3, 3, 1'b0);
      bus.clr     = 1'b1;
      bus.din_vld = 1'b1;
      tick();
      bus.clr     = 1'b0;
      bus.din_vld = 1'b0;
      hist.delete();
      ovf_exp = 1'b0;
      check("clr_drdy", 32'(bus.drdy), 32'd0);
      check("clr_ovf", 32'(bus.ovf), 32'd0);
      check("clr_busy", 32'(bus.busy), 32'd0);
      run_frame(32'h0000_0005, 3, 1'b0);

      // Random frames, taps_m1 scrambled and frames poked mid-run.
      run_frame($urandom, 3, 1'b1);
      run_frame($urandom, 10, 1'b1);
      for (int i = 0; i < 6; i++) run_frame($urandom, $urandom_range(0, 12), 1'b1);

      // Async reset between edges mid-run.
      start_frame($urandom, 5);
      check_beats(5, 2, 1'b0);
      #2;
      tb_rstn = 1'b0;
      #1;
      check("arst_dout", 32'(bus.dout), 32'd0);
      check("arst_drdy", 32'(bus.drdy), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_ovf", 32'(bus.ovf), 32'd0);
      check("arst_tap", 32'(bus.dout_tap), 32'd0);
      check("arst_first", 32'(bus.dfirst | bus.dlast), 32'd0);
      hist.delete();
      ovf_exp = 1'b0;
      tick();
      tb_rstn = 1'b1;
      tick();
      run_frame($urandom, 3, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
